// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, step encodings,
// instruction classes and the ALU one-hot codes it drives into the datapath.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // alu_op is one-hot {OR, AND, SUB, ADD}
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b1000;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_IMM,
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_MFHI,
        CLS_MFLO,
        CLS_HALT
    } instr_class_t;

    // True in the final execute step of an instruction, where the next edge
    // returns to fetch (or to HALT when stop is requested).
    function automatic logic is_last_step(input state_t s, input instr_class_t c);
        case (s)
            S_T3:    return c inside {CLS_MFHI, CLS_MFLO, CLS_NOP};
            S_T5:    return c inside {CLS_RTYPE, CLS_IMM, CLS_LDI};
            S_T7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// IR contents and halt request in, every datapath strobe out.
interface control_sequencer_if #(parameter int IRW = 32);

    logic [IRW-1:0] ir;
    logic           stop;

    logic PCout, Zlowout, MDRout, HIout, LOout, Csignout, BAout, Rout;
    logic MARin, PCin, MDRin, IRin, Yin, Zlowin, Rin, HIin, LOin;
    logic Gra, Grb, Grc;
    logic Read, Write, MD_read;
    logic IncPC;
    logic [3:0] alu_op;
    logic run;

    modport master (
        input  ir, stop,
        output PCout, Zlowout, MDRout, HIout, LOout, Csignout, BAout, Rout,
        output MARin, PCin, MDRin, IRin, Yin, Zlowin, Rin, HIin, LOin,
        output Gra, Grb, Grc, Read, Write, MD_read, IncPC, alu_op, run
    );

    modport slave (
        output ir, stop,
        input  PCout, Zlowout, MDRout, HIout, LOout, Csignout, BAout, Rout,
        input  MARin, PCin, MDRin, IRin, Yin, Zlowin, Rin, HIin, LOin,
        input  Gra, Grb, Grc, Read, Write, MD_read, IncPC, alu_op, run
    );

endinterface

// File: rtl/ctrl_decode.sv
// Opcode decoder: maps the IR opcode field to an instruction class and the
// ALU operation used in that class's arithmetic step.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output instr_class_t   cls,
    output logic [3:0]     alu_op
);

    // Undefined opcodes fall into CLS_NOP so they run as a plain 4-step nop.
    always_comb begin
        cls    = CLS_NOP;
        alu_op = ALU_NONE;
        case (opcode)
            OP_LD:   begin cls = CLS_LD;    alu_op = ALU_ADD; end
            OP_LDI:  begin cls = CLS_LDI;   alu_op = ALU_ADD; end
            OP_ST:   begin cls = CLS_ST;    alu_op = ALU_ADD; end
            OP_ADD:  begin cls = CLS_RTYPE; alu_op = ALU_ADD; end
            OP_SUB:  begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
            OP_AND:  begin cls = CLS_RTYPE; alu_op = ALU_AND; end
            OP_OR:   begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
            OP_ADDI: begin cls = CLS_IMM;   alu_op = ALU_ADD; end
            OP_ANDI: begin cls = CLS_IMM;   alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_IMM;   alu_op = ALU_OR;  end
            OP_MFHI: cls = CLS_MFHI;
            OP_MFLO: cls = CLS_MFLO;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch T0-T2, decodes IR, then runs the per-class
// execute sequence, driving Moore strobes into the datapath one step per clock.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IRW = 32,
    parameter int OPW = 5
) (
    input  logic clock,
    input  logic clear,
    control_sequencer_if.master bus
);

    state_t         state;
    instr_class_t   cls;
    logic [3:0]     dec_alu;
    logic [OPW-1:0] opcode;
    logic           unused_ir_low;

    assign opcode        = bus.ir[IRW-1 -: OPW];
    assign unused_ir_low = ^bus.ir[IRW-OPW-1:0];

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode (opcode),
        .cls    (cls),
        .alu_op (dec_alu)
    );

    // stop is only looked at on the edge that would re-enter T0, so an
    // instruction already in flight always completes.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST:  state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3: begin
                    if (cls == CLS_HALT)
                        state <= S_HALT;
                    else if (is_last_step(state, cls))
                        state <= bus.stop ? S_HALT : S_T0;
                    else
                        state <= S_T4;
                end
                S_T4:   state <= S_T5;
                S_T5: begin
                    if (is_last_step(state, cls))
                        state <= bus.stop ? S_HALT : S_T0;
                    else
                        state <= S_T6;
                end
                S_T6:   state <= S_T7;
                S_T7:   state <= bus.stop ? S_HALT : S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
        bus.Csignout = 1'b0;
        bus.BAout    = 1'b0;
        bus.Rout     = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zlowin   = 1'b0;
        bus.Rin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Read     = 1'b0;
        bus.Write    = 1'b0;
        bus.MD_read  = 1'b0;
        bus.IncPC    = 1'b0;
        bus.alu_op   = ALU_NONE;
        bus.run      = (state >= S_T0) && (state <= S_T7);

        case (state)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MD_read = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_RTYPE, CLS_IMM: begin
                        bus.Grb  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                    // Memory and ldi forms use BAout so R0 reads as zero base.
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        bus.Grb   = 1'b1;
                        bus.BAout = 1'b1;
                        bus.Yin   = 1'b1;
                    end
                    CLS_MFHI: begin
                        bus.HIout = 1'b1;
                        bus.Gra   = 1'b1;
                        bus.Rin   = 1'b1;
                    end
                    CLS_MFLO: begin
                        bus.LOout = 1'b1;
                        bus.Gra   = 1'b1;
                        bus.Rin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_RTYPE: begin
                        bus.Grc    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.alu_op = dec_alu;
                        bus.Zlowin = 1'b1;
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        bus.Csignout = 1'b1;
                        bus.alu_op   = dec_alu;
                        bus.Zlowin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CLS_RTYPE, CLS_IMM, CLS_LDI: begin
                        bus.Zlowout = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.Rin     = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        bus.Zlowout = 1'b1;
                        bus.MARin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CLS_LD: begin
                        bus.Read    = 1'b1;
                        bus.MD_read = 1'b1;
                        bus.MDRin   = 1'b1;
                    end
                    CLS_ST: begin
                        bus.Gra   = 1'b1;
                        bus.Rout  = 1'b1;
                        bus.MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CLS_LD: begin
                        bus.MDRout = 1'b1;
                        bus.Gra    = 1'b1;
                        bus.Rin    = 1'b1;
                    end
                    CLS_ST: bus.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction sequences plus
// randomized instruction/stop streams checked against a step-table reference model.
module tb_control_sequencer;

    localparam logic [4:0] T_LD   = 5'b00000;
    localparam logic [4:0] T_LDI  = 5'b00001;
    localparam logic [4:0] T_ST   = 5'b00010;
    localparam logic [4:0] T_ADD  = 5'b00011;
    localparam logic [4:0] T_SUB  = 5'b00100;
    localparam logic [4:0] T_AND  = 5'b00101;
    localparam logic [4:0] T_OR   = 5'b00110;
    localparam logic [4:0] T_ADDI = 5'b01100;
    localparam logic [4:0] T_ANDI = 5'b01101;
    localparam logic [4:0] T_ORI  = 5'b01110;
    localparam logic [4:0] T_MFHI = 5'b11000;
    localparam logic [4:0] T_MFLO = 5'b11001;
    localparam logic [4:0] T_NOP  = 5'b11010;
    localparam logic [4:0] T_HALT = 5'b11011;

    localparam logic [28:0] M_PCOUT    = 29'd1 << 0;
    localparam logic [28:0] M_ZLOWOUT  = 29'd1 << 1;
    localparam logic [28:0] M_MDROUT   = 29'd1 << 2;
    localparam logic [28:0] M_HIOUT    = 29'd1 << 3;
    localparam logic [28:0] M_LOOUT    = 29'd1 << 4;
    localparam logic [28:0] M_CSIGNOUT = 29'd1 << 5;
    localparam logic [28:0] M_BAOUT    = 29'd1 << 6;
    localparam logic [28:0] M_ROUT     = 29'd1 << 7;
    localparam logic [28:0] M_MARIN    = 29'd1 << 8;
    localparam logic [28:0] M_PCIN     = 29'd1 << 9;
    localparam logic [28:0] M_MDRIN    = 29'd1 << 10;
    localparam logic [28:0] M_IRIN     = 29'd1 << 11;
    localparam logic [28:0] M_YIN      = 29'd1 << 12;
    localparam logic [28:0] M_ZLOWIN   = 29'd1 << 13;
    localparam logic [28:0] M_RIN      = 29'd1 << 14;
    localparam logic [28:0] M_GRA      = 29'd1 << 17;
    localparam logic [28:0] M_GRB      = 29'd1 << 18;
    localparam logic [28:0] M_GRC      = 29'd1 << 19;
    localparam logic [28:0] M_READ     = 29'd1 << 20;
    localparam logic [28:0] M_WRITE    = 29'd1 << 21;
    localparam logic [28:0] M_MDREAD   = 29'd1 << 22;
    localparam logic [28:0] M_INCPC    = 29'd1 << 23;
    localparam logic [28:0] M_RUN      = 29'd1 << 28;

    logic clock;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    control_sequencer_if #(.IRW(32)) bus ();

    control_sequencer #(.IRW(32), .OPW(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: ALU code, instruction length and per-step strobe set.
    function automatic logic [3:0] alu_for(input logic [4:0] op);
        case (op)
            T_SUB:          return 4'b0010;
            T_AND, T_ANDI:  return 4'b0100;
            T_OR, T_ORI:    return 4'b1000;
            default:        return 4'b0001;
        endcase
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        case (op)
            T_LD, T_ST: return 8;
            T_ADD, T_SUB, T_AND, T_OR, T_ADDI, T_ANDI, T_ORI, T_LDI: return 6;
            default: return 4;
        endcase
    endfunction

    function automatic logic [28:0] exec_vec(input logic [4:0] op, input int k);
        logic [28:0] alu;
        alu = {1'b0, alu_for(op), 24'd0};
        case (op)
            T_ADD, T_SUB, T_AND, T_OR:
                case (k)
                    0: return M_GRB | M_ROUT | M_YIN;
                    1: return M_GRC | M_ROUT | alu | M_ZLOWIN;
                    default: return M_ZLOWOUT | M_GRA | M_RIN;
                endcase
            T_ADDI, T_ANDI, T_ORI:
                case (k)
                    0: return M_GRB | M_ROUT | M_YIN;
                    1: return M_CSIGNOUT | alu | M_ZLOWIN;
                    default: return M_ZLOWOUT | M_GRA | M_RIN;
                endcase
            T_LDI:
                case (k)
                    0: return M_GRB | M_BAOUT | M_YIN;
                    1: return M_CSIGNOUT | alu | M_ZLOWIN;
                    default: return M_ZLOWOUT | M_GRA | M_RIN;
                endcase
            T_LD, T_ST:
                case (k)
                    0: return M_GRB | M_BAOUT | M_YIN;
                    1: return M_CSIGNOUT | alu | M_ZLOWIN;
                    2: return M_ZLOWOUT | M_MARIN;
                    3: return (op == T_LD) ? (M_READ | M_MDREAD | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
                    default: return (op == T_LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
                endcase
            T_MFHI: return M_HIOUT | M_GRA | M_RIN;
            T_MFLO: return M_LOOUT | M_GRA | M_RIN;
            default: return 29'd0;
        endcase
    endfunction

    function automatic logic [28:0] step_vec(input logic [4:0] op, input int step);
        case (step)
            0: return M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
            1: return M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDREAD | M_MDRIN;
            2: return M_RUN | M_MDROUT | M_IRIN;
            default: return M_RUN | exec_vec(op, step - 3);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [28:0] expected);
        logic [28:0] observed;
        observed = {bus.run, bus.alu_op, bus.IncPC, bus.MD_read, bus.Write, bus.Read,
                    bus.Grc, bus.Grb, bus.Gra, bus.LOin, bus.HIin, bus.Rin, bus.Zlowin,
                    bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.MARin, bus.Rout, bus.BAout,
                    bus.Csignout, bus.LOout, bus.HIout, bus.MDRout, bus.Zlowout, bus.PCout};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulses clear across one cycle, leaving the sequencer in T0 at the next negedge.
    task automatic applyReset();
        clear = 1'b0;
        @(negedge clock);
        checkOutput("reset_hold", 29'd0);
        clear = 1'b1;
        @(negedge clock);
    endtask

    // Entered at the negedge inside T0; leaves at the negedge of the following state.
    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input int stop_on, input bit hold, input int abort_at,
                                 output bit halt_exp);
        logic [4:0] op;
        int len;
        op  = instr[31:27];
        len = instr_len(op);
        halt_exp = (op == T_HALT) || ((stop_on >= 0) && (hold || stop_on == len - 1));
        for (int s = 0; s < len; s++) begin
            bus.ir = (s == 2) ? instr : (s < 2 ? $urandom : instr);
            checkOutput($sformatf("%s_T%0d", name, s), step_vec(op, s));
            if (s == abort_at) begin
                #1 clear = 1'b0;
                #1 checkOutput($sformatf("%s_async_clear", name), 29'd0);
                halt_exp = 1'b0;
                break;
            end
            if (s == stop_on) bus.stop = 1'b1;
            else if (!hold) bus.stop = 1'b0;
            @(negedge clock);
        end
        bus.stop = 1'b0;
    endtask

    logic [4:0] ops [14] = '{T_LD, T_LDI, T_ST, T_ADD, T_SUB, T_AND, T_OR,
                             T_ADDI, T_ANDI, T_ORI, T_MFHI, T_MFLO, T_NOP, T_HALT};

    initial begin
        bit halted;
        logic [4:0] op;
        logic [31:0] instr;
        int stop_on;
        bit hold;

        clear    = 1'b0;
        bus.stop = 1'b0;
        bus.ir   = 32'd0;

        @(negedge clock);
        checkOutput("reset_state", 29'd0);
        clear = 1'b1;
        @(negedge clock);

        applyStimulus("add_abort", 32'h18918000, -1, 1'b0, 4, halted);
        applyReset();

        applyStimulus("add",  32'h18918000, -1, 1'b0, -1, halted);
        applyStimulus("mfhi", 32'hC1000000, -1, 1'b0, -1, halted);
        applyStimulus("ld",   32'h00800055, -1, 1'b0, -1, halted);
        applyStimulus("st",   32'h10800055, -1, 1'b0, -1, halted);
        applyStimulus("nop",  32'hD0000000, -1, 1'b0, -1, halted);
        applyStimulus("undef", 32'hF8000000, -1, 1'b0, -1, halted);
        applyStimulus("addi_stop_t0", 32'h61000005, 0, 1'b0, -1, halted);

        applyStimulus("addi_stop_t4", 32'h61000005, 4, 1'b1, -1, halted);
        checkOutput("addi_stop_halt", 29'd0);
        applyReset();

        applyStimulus("halt", 32'hD8000000, -1, 1'b0, -1, halted);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("halt_hold_%0d", i), 29'd0);
            @(negedge clock);
        end
        applyReset();

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ops[$urandom_range(0, 13)];
            instr = {op, 27'($urandom)};
            stop_on = ($urandom_range(0, 3) == 0) ? $urandom_range(0, instr_len(op) - 1) : -1;
            hold = 1'($urandom);
            applyStimulus($sformatf("rand%0d_op%0h", n, op), instr, stop_on, hold, -1, halted);
            if (halted) begin
                checkOutput($sformatf("rand%0d_halt", n), 29'd0);
                applyReset();
            end
        end
        checkOutput("final_t0", step_vec(T_NOP, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
